// File: rtl/axi_lite_arbiter.sv
// AXI-lite arbiter: shares one slave port among NUM_M masters.
// Each grant covers one complete read (address + data) or one complete
// write (address + data). Masters are picked round-robin from rr_ptr.
// There is no write response channel on this bus.
module axi_lite_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rstn,

    // Master side
    input  logic [NUM_M*ADDR_W-1:0]   m_read_addr,
    input  logic [NUM_M-1:0]          m_read_addr_valid,
    output logic [NUM_M-1:0]          m_read_addr_ready,
    output logic [DATA_W-1:0]         m_read_data,
    output logic [NUM_M-1:0]          m_read_data_valid,
    input  logic [NUM_M-1:0]          m_read_data_ready,
    input  logic [NUM_M*ADDR_W-1:0]   m_write_addr,
    input  logic [NUM_M-1:0]          m_write_addr_valid,
    output logic [NUM_M-1:0]          m_write_addr_ready,
    input  logic [NUM_M*DATA_W-1:0]   m_write_data,
    input  logic [NUM_M-1:0]          m_write_data_valid,
    output logic [NUM_M-1:0]          m_write_data_ready,

    // Slave side
    output logic [ADDR_W-1:0]         s_read_addr,
    output logic                      s_read_addr_valid,
    input  logic                      s_read_addr_ready,
    input  logic [DATA_W-1:0]         s_read_data,
    input  logic                      s_read_data_valid,
    output logic                      s_read_data_ready,
    output logic [ADDR_W-1:0]         s_write_addr,
    output logic                      s_write_addr_valid,
    input  logic                      s_write_addr_ready,
    output logic [DATA_W-1:0]         s_write_data,
    output logic                      s_write_data_valid,
    input  logic                      s_write_data_ready,

    // Status
    output logic [NUM_M-1:0]          grant,
    output logic                      busy
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   g_idx;      // index of the granted master
    logic [IDX_W-1:0]   rr_ptr;     // first master checked at next arbitration
    logic               ar_done;    // read address accepted, now in data phase
    logic               aw_done;
    logic               w_done;

    logic [NUM_M-1:0]   req;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   next_ptr;

    logic               rd_addr_phase;
    logic               rd_data_phase;
    logic               wr_addr_open;
    logic               wr_data_open;
    logic               ar_hs;
    logic               r_hs;
    logic               aw_hs;
    logic               w_hs;

    assign req = m_read_addr_valid | m_write_addr_valid;

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // through this block leaves it unassigned, which would infer a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (!sel_found && req[(int'(rr_ptr) + k) % NUM_M]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_M);
            end
        end
    end

    assign next_ptr = (g_idx == IDX_W'(NUM_M - 1)) ? '0 : g_idx + 1'b1;

    // Channel phase qualifiers; all are low in IDLE.
    assign rd_addr_phase = (state == READ)  && !ar_done;
    assign rd_data_phase = (state == READ)  &&  ar_done;
    assign wr_addr_open  = (state == WRITE) && !aw_done;
    assign wr_data_open  = (state == WRITE) && !w_done;

    // Slave-side controls, gated copies of the granted master's signals.
    assign s_read_addr_valid  = rd_addr_phase && m_read_addr_valid[g_idx];
    assign s_read_data_ready  = rd_data_phase && m_read_data_ready[g_idx];
    assign s_write_addr_valid = wr_addr_open  && m_write_addr_valid[g_idx];
    assign s_write_data_valid = wr_data_open  && m_write_data_valid[g_idx];

    assign s_read_addr  = (state == READ)  ? m_read_addr[g_idx*ADDR_W +: ADDR_W]  : '0;
    assign s_write_addr = (state == WRITE) ? m_write_addr[g_idx*ADDR_W +: ADDR_W] : '0;
    assign s_write_data = (state == WRITE) ? m_write_data[g_idx*DATA_W +: DATA_W] : '0;

    // grant is one-hot in a transaction and zero in IDLE, so masking with it
    // routes each response to the granted master only.
    assign m_read_addr_ready  = grant & {NUM_M{rd_addr_phase && s_read_addr_ready}};
    assign m_read_data_valid  = grant & {NUM_M{rd_data_phase && s_read_data_valid}};
    assign m_write_addr_ready = grant & {NUM_M{wr_addr_open  && s_write_addr_ready}};
    assign m_write_data_ready = grant & {NUM_M{wr_data_open  && s_write_data_ready}};
    assign m_read_data        = s_read_data;

    assign ar_hs = s_read_addr_valid  && s_read_addr_ready;
    assign r_hs  = s_read_data_ready  && s_read_data_valid;
    assign aw_hs = s_write_addr_valid && s_write_addr_ready;
    assign w_hs  = s_write_data_valid && s_write_data_ready;

    assign busy = (state != IDLE);

    // Transaction FSM: arbitrate in IDLE, track handshakes in READ/WRITE.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state   <= IDLE;
            grant   <= '0;
            g_idx   <= '0;
            rr_ptr  <= '0;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant <= NUM_M'(1) << sel_idx;
                        g_idx <= sel_idx;
                        // A write request outranks a read from the same master.
                        state <= m_write_addr_valid[sel_idx] ? WRITE : READ;
                    end
                end
                READ: begin
                    if (ar_hs) begin
                        ar_done <= 1'b1;
                    end
                    if (r_hs) begin
                        state   <= IDLE;
                        grant   <= '0;
                        ar_done <= 1'b0;
                        rr_ptr  <= next_ptr;
                    end
                end
                WRITE: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state   <= IDLE;
                        grant   <= '0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        rr_ptr  <= next_ptr;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed testbench for axi_lite_arbiter with two masters.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_axi_lite_arbiter;

    localparam int NUM_M = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic                 clk = 1'b0;
    logic                 rstn;

    logic [NUM_M*AW-1:0]  m_read_addr;
    logic [NUM_M-1:0]     m_read_addr_valid;
    logic [NUM_M-1:0]     m_read_addr_ready;
    logic [DW-1:0]        m_read_data;
    logic [NUM_M-1:0]     m_read_data_valid;
    logic [NUM_M-1:0]     m_read_data_ready;
    logic [NUM_M*AW-1:0]  m_write_addr;
    logic [NUM_M-1:0]     m_write_addr_valid;
    logic [NUM_M-1:0]     m_write_addr_ready;
    logic [NUM_M*DW-1:0]  m_write_data;
    logic [NUM_M-1:0]     m_write_data_valid;
    logic [NUM_M-1:0]     m_write_data_ready;
    logic [AW-1:0]        s_read_addr;
    logic                 s_read_addr_valid;
    logic                 s_read_addr_ready;
    logic [DW-1:0]        s_read_data;
    logic                 s_read_data_valid;
    logic                 s_read_data_ready;
    logic [AW-1:0]        s_write_addr;
    logic                 s_write_addr_valid;
    logic                 s_write_addr_ready;
    logic [DW-1:0]        s_write_data;
    logic                 s_write_data_valid;
    logic                 s_write_data_ready;
    logic [NUM_M-1:0]     grant;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_arbiter #(.NUM_M(NUM_M), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .m_read_addr        (m_read_addr),
        .m_read_addr_valid  (m_read_addr_valid),
        .m_read_addr_ready  (m_read_addr_ready),
        .m_read_data        (m_read_data),
        .m_read_data_valid  (m_read_data_valid),
        .m_read_data_ready  (m_read_data_ready),
        .m_write_addr       (m_write_addr),
        .m_write_addr_valid (m_write_addr_valid),
        .m_write_addr_ready (m_write_addr_ready),
        .m_write_data       (m_write_data),
        .m_write_data_valid (m_write_data_valid),
        .m_write_data_ready (m_write_data_ready),
        .s_read_addr        (s_read_addr),
        .s_read_addr_valid  (s_read_addr_valid),
        .s_read_addr_ready  (s_read_addr_ready),
        .s_read_data        (s_read_data),
        .s_read_data_valid  (s_read_data_valid),
        .s_read_data_ready  (s_read_data_ready),
        .s_write_addr       (s_write_addr),
        .s_write_addr_valid (s_write_addr_valid),
        .s_write_addr_ready (s_write_addr_ready),
        .s_write_data       (s_write_data),
        .s_write_data_valid (s_write_data_valid),
        .s_write_data_ready (s_write_data_ready),
        .grant              (grant),
        .busy               (busy)
    );

    typedef struct {
        bit          wr;
        int          m;
        logic [31:0] addr;
        logic [31:0] data;
        int          aw;     // address-channel wait cycles
        int          dw;     // data wait cycles (read: slave valid; write: slave ready)
        int          rw;     // read only: cycles master holds data ready low
        logic [1:0]  exp_g;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_read_addr        = '0;
        m_read_addr_valid  = '0;
        m_read_data_ready  = '0;
        m_write_addr       = '0;
        m_write_addr_valid = '0;
        m_write_data       = '0;
        m_write_data_valid = '0;
        s_read_addr_ready  = 1'b0;
        s_read_data        = '0;
        s_read_data_valid  = 1'b0;
        s_write_addr_ready = 1'b0;
        s_write_data_ready = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_grant"}, grant, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_s_ctl"}, {s_read_addr_valid, s_write_addr_valid,
                                 s_write_data_valid, s_read_data_ready}, 0);
        check({name, "_m_ctl"}, {m_read_addr_ready, m_read_data_valid,
                                 m_write_addr_ready, m_write_data_ready}, 0);
    endtask

    task automatic set_rd_req(input int m, input logic [31:0] addr);
        m_read_addr[m*AW +: AW] = addr;
        m_read_addr_valid[m]    = 1'b1;
    endtask

    task automatic set_wr_req(input int m, input logic [31:0] addr, input logic [31:0] data);
        m_write_addr[m*AW +: AW] = addr;
        m_write_data[m*DW +: DW] = data;
        m_write_addr_valid[m]    = 1'b1;
        m_write_data_valid[m]    = 1'b1;
    endtask

    // Entered just after a falling edge with master m already granted a READ.
    task automatic run_read(input int m, input logic [31:0] addr, input logic [31:0] data,
                            input int aw, input int dw, input int rw, input logic [1:0] g);
        for (int c = 0; c <= aw; c++) begin
            s_read_addr_ready = (c == aw);
            #1;
            check("rd_grant", grant, g);
            check("rd_ar_valid", s_read_addr_valid, 1);
            check("rd_addr", s_read_addr, addr);
            check("rd_ar_ready", m_read_addr_ready, (c == aw) ? g : 2'b00);
            tick();
        end
        m_read_addr_valid[m] = 1'b0;
        s_read_addr_ready    = 1'b0;
        s_read_data          = data;
        for (int c = 0; c <= dw + rw; c++) begin
            s_read_data_valid    = (c >= dw);
            m_read_data_ready[m] = (c >= dw + rw);
            #1;
            check("rd_b_grant", grant, g);
            check("rd_b_busy", busy, 1);
            check("rd_b_ar_valid", s_read_addr_valid, 0);
            check("rd_r_valid", m_read_data_valid, (c >= dw) ? g : 2'b00);
            check("rd_r_ready", s_read_data_ready, (c == dw + rw));
            check("rd_data", m_read_data, data);
            tick();
        end
        s_read_data_valid    = 1'b0;
        m_read_data_ready[m] = 1'b0;
        #1;
        check("rd_end_busy", busy, 0);
        check("rd_end_grant", grant, 0);
    endtask

    // Entered just after a falling edge with master m already granted a WRITE.
    // The master keeps write data valid up to completion, so the arbiter must
    // mask it itself once the data handshake is done.
    task automatic run_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                             input int aw, input int ww, input logic [1:0] g);
        bit a_seen = 1'b0;
        bit w_seen = 1'b0;
        int c = 0;
        while (!(a_seen && w_seen) && c < 64) begin
            s_write_addr_ready = !a_seen && (c >= aw);
            s_write_data_ready = !w_seen && (c >= ww);
            #1;
            check("wr_grant", grant, g);
            check("wr_busy", busy, 1);
            check("wr_aw_valid", s_write_addr_valid, !a_seen);
            check("wr_w_valid", s_write_data_valid, !w_seen);
            check("wr_addr", s_write_addr, addr);
            check("wr_data", s_write_data, data);
            check("wr_aw_ready", m_write_addr_ready, s_write_addr_ready ? g : 2'b00);
            check("wr_w_ready", m_write_data_ready, s_write_data_ready ? g : 2'b00);
            check("wr_ar_valid", s_read_addr_valid, 0);
            if (s_write_addr_ready) a_seen = 1'b1;
            if (s_write_data_ready) w_seen = 1'b1;
            tick();
            if (a_seen) m_write_addr_valid[m] = 1'b0;
            c++;
        end
        m_write_addr_valid[m] = 1'b0;
        m_write_data_valid[m] = 1'b0;
        s_write_addr_ready    = 1'b0;
        s_write_data_ready    = 1'b0;
        #1;
        check("wr_end_busy", busy, 0);
        check("wr_end_grant", grant, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{wr:0, m:0, addr:32'h10,   data:32'hDEADBEEF, aw:0, dw:2, rw:0, exp_g:2'b01};
        vecs[1] = '{wr:0, m:1, addr:32'h1234, data:32'h0BADF00D, aw:1, dw:0, rw:0, exp_g:2'b10};
        vecs[2] = '{wr:1, m:1, addr:32'h20,   data:32'hA5A5A5A5, aw:3, dw:0, rw:0, exp_g:2'b10};
        vecs[3] = '{wr:1, m:0, addr:32'h44,   data:32'h11223344, aw:0, dw:2, rw:0, exp_g:2'b01};
        vecs[4] = '{wr:1, m:0, addr:32'h48,   data:32'h55667788, aw:1, dw:1, rw:0, exp_g:2'b01};
        vecs[5] = '{wr:0, m:0, addr:32'h30,   data:32'hCAFEF00D, aw:0, dw:0, rw:5, exp_g:2'b01};
        vecs[6] = '{wr:0, m:1, addr:32'h58,   data:32'h600DCAFE, aw:2, dw:1, rw:1, exp_g:2'b10};

        // Reset state
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        #1;
        check_quiet("reset");
        tick();
        rstn = 1'b1;

        // Contention from reset: m0 first, then m1 (rr_ptr ends at 0)
        tick();
        set_rd_req(0, 32'h100);
        set_rd_req(1, 32'h200);
        #1;
        check("cont1_latency_grant", grant, 0);
        check("cont1_latency_ar", s_read_addr_valid, 0);
        tick();
        run_read(0, 32'h100, 32'h11110000, 0, 0, 0, 2'b01);
        tick();
        run_read(1, 32'h200, 32'h22220000, 0, 0, 0, 2'b10);

        // Lone m0 read moves rr_ptr to 1
        tick();
        set_rd_req(0, 32'h104);
        tick();
        run_read(0, 32'h104, 32'h33330000, 0, 1, 0, 2'b01);

        // Contention again: m1 first now, then m0 (rr_ptr ends at 1)
        tick();
        set_rd_req(0, 32'h108);
        set_rd_req(1, 32'h208);
        tick();
        run_read(1, 32'h208, 32'h44440000, 0, 0, 0, 2'b10);
        tick();
        run_read(0, 32'h108, 32'h55550000, 0, 0, 0, 2'b01);

        // m0 read + write together: write first; m1 joins, then round-robin
        tick();
        set_rd_req(0, 32'h30);
        set_wr_req(0, 32'h40, 32'h0F0F0F0F);
        tick();
        set_rd_req(1, 32'h300);
        run_write(0, 32'h40, 32'h0F0F0F0F, 0, 0, 2'b01);
        tick();
        run_read(1, 32'h300, 32'h66660000, 0, 0, 0, 2'b10);
        tick();
        run_read(0, 32'h30, 32'h77770000, 0, 0, 0, 2'b01);

        // Asynchronous reset during read data phase
        tick();
        set_rd_req(0, 32'h50);
        tick();
        s_read_addr_ready = 1'b1;
        #1;
        check("rstmid_grant", grant, 2'b01);
        tick();
        m_read_addr_valid[0] = 1'b0;
        s_read_addr_ready    = 1'b0;
        s_read_data          = 32'h99990000;
        s_read_data_valid    = 1'b1;
        m_read_data_ready[0] = 1'b1;
        #1;
        check("rstmid_r_valid", m_read_data_valid, 2'b01);
        check("rstmid_r_ready", s_read_data_ready, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_quiet("rstmid");
        tick();
        clear_inputs();
        tick();
        rstn = 1'b1;

        // After reset rr_ptr is 0 again: m0 wins contention
        tick();
        set_rd_req(0, 32'h60);
        set_rd_req(1, 32'h64);
        tick();
        run_read(0, 32'h60, 32'h88880000, 0, 0, 0, 2'b01);
        tick();
        run_read(1, 32'h64, 32'h88881111, 0, 0, 0, 2'b10);

        // Table of single-master transactions
        for (int i = 0; i < 7; i++) begin
            tick();
            if (vecs[i].wr) set_wr_req(vecs[i].m, vecs[i].addr, vecs[i].data);
            else            set_rd_req(vecs[i].m, vecs[i].addr);
            #1;
            check("vec_latency_grant", grant, 0);
            check("vec_latency_valid", {s_read_addr_valid, s_write_addr_valid}, 0);
            tick();
            if (vecs[i].wr)
                run_write(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].aw, vecs[i].dw, vecs[i].exp_g);
            else
                run_read(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].aw, vecs[i].dw,
                         vecs[i].rw, vecs[i].exp_g);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Shares one AXI-lite slave port (read address/data, write address/data channels; no write response channel) among NUM_M masters.
- Each grant covers one whole transaction: one read (address + data) or one write (address + data).
- Masters are selected round-robin.
- Sits between the test/master side and the DUT side of the AXI_if bus, using the same channel signal names with m_/s_ prefixes.

Parameters:
- NUM_M, 2, number of masters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  input  1  clock; all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- m_read_addr  input  NUM_M*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
- m_read_addr_valid  input  NUM_M  per-master read request
- m_read_addr_ready  output  NUM_M  read address accepted
- m_read_data  output  DATA_W  broadcast copy of s_read_data
- m_read_data_valid  output  NUM_M  read data valid, granted master only
- m_read_data_ready  input  NUM_M  master accepts read data
- m_write_addr  input  NUM_M*ADDR_W  packed like m_read_addr
- m_write_addr_valid  input  NUM_M  per-master write request
- m_write_addr_ready  output  NUM_M  write address accepted
- m_write_data  input  NUM_M*DATA_W  packed write data
- m_write_data_valid  input  NUM_M  write data valid
- m_write_data_ready  output  NUM_M  write data accepted
- s_read_addr, s_write_addr  output  ADDR_W  muxed from granted master
- s_write_data  output  DATA_W  muxed from granted master
- s_read_addr_valid, s_write_addr_valid, s_write_data_valid, s_read_data_ready  output  1  gated copies for the granted master
- s_read_addr_ready, s_write_addr_ready, s_write_data_ready, s_read_data_valid  input  1  from slave
- s_read_data  input  DATA_W  from slave
- grant  output  NUM_M  one-hot active grant; 0 in IDLE
- busy  output  1  high when state is not IDLE

Behaviour:
- States: IDLE, READ, WRITE. State, grant, rr_ptr, aw_done and w_done are registered.
- Reset (asynchronous, immediate, even mid-transaction):
  - state=IDLE, grant=0, rr_ptr=0, aw_done=w_done=0.
  - All s_*valid, s_read_data_ready, m_*ready and m_read_data_valid are 0.
  - No partial transaction is resumed after reset.
- Request of master i: m_read_addr_valid[i] or m_write_addr_valid[i].
- IDLE arbitration:
  - Choose the first requesting master scanning from rr_ptr upward, wrapping mod NUM_M.
  - Register its grant and go to WRITE if its m_write_addr_valid is set (write wins over read from the same master), else READ.
  - No requests: stay in IDLE.
- Latency: a request sampled in cycle N produces the s_ valid in cycle N+1 at the earliest. All slave-side outputs are 0 in IDLE.
- Muxing: s_ outputs are combinational selects by grant. Non-granted masters always see ready=0 and m_read_data_valid=0.
- READ:
  - Phase A: s_read_addr_valid = m_read_addr_valid[g]; m_read_addr_ready[g] = s_read_addr_ready.
  - Phase B starts the cycle after the address handshake. s_read_addr_valid is forced to 0 in phase B.
  - Phase B: m_read_data_valid[g] = s_read_data_valid; s_read_data_ready = m_read_data_ready[g].
  - On the data handshake: go to IDLE, rr_ptr=(g+1) mod NUM_M.
- WRITE:
  - Address and data channels run independently. aw_done/w_done set on their handshakes; each valid is forced to 0 once its done flag is set.
  - Handshakes may complete in the same cycle or in either order.
  - When both are done (including the completing cycle): go to IDLE, clear the flags, rr_ptr=(g+1) mod NUM_M.
- Backpressure: any number of wait cycles on any channel. The arbiter holds state and grant and never times out.
- A master dropping valid before its handshake is a protocol violation. The arbiter keeps waiting in the current state.
- Back-to-back: at least one IDLE cycle between transactions.

Test Plan:
- Reset, m0 read 0x10, slave returns 0xDEADBEEF with 2 wait cycles → grant=01 for the whole transaction; m0 receives 0xDEADBEEF with m_read_data_valid[0] for exactly 1 handshake; busy falls the cycle after the handshake.
- After reset, m0 and m1 both read simultaneously → m0 served first, then m1. Repeat contention → m1 served first (rr_ptr=1), then m0.
- m1 write addr 0x20, data 0xA5A5A5A5; slave takes data 3 cycles before address → s_write_data_valid drops after the data handshake; return to IDLE only after the address handshake.
- m0 asserts read 0x30 and write 0x40 in the same cycle → WRITE first; READ granted on the next arbitration after m1 (if requesting) per round-robin.
- m0 holds m_read_data_ready low 5 cycles while s_read_data_valid=1 → s_read_data_ready stays 0, state stays READ; completes when ready rises.
- rstn pulsed low during READ phase B → all valids/readies and grant go to 0 immediately (asynchronously); after release, a new m1 request is granted from rr_ptr=0 (m0 is checked first).
